// File: rtl/ide_host_pkg.sv
// Shared types and constants for the host-side ATA PIO engine.
package ide_host_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_STROBE  = 3'd2,
    S_WAITRDY = 3'd3,
    S_HOLD    = 3'd4,
    S_RECOVER = 3'd5,
    S_RSTLO   = 3'd6
  } state_t;

  // Strobe and chip-select levels on the bus (both active low)
  localparam logic STROBE_ASSERT = 1'b0;
  localparam logic STROBE_NEGATE = 1'b1;
  localparam logic CS_SELECT     = 1'b0;
  localparam logic CS_IDLE       = 1'b1;

  // Command block registers (CS0-)
  localparam logic [2:0] REG_DATA     = 3'd0;
  localparam logic [2:0] REG_ERROR    = 3'd1;
  localparam logic [2:0] REG_FEATURES = 3'd1;
  localparam logic [2:0] REG_SECCNT   = 3'd2;
  localparam logic [2:0] REG_LBA_LO   = 3'd3;
  localparam logic [2:0] REG_LBA_MID  = 3'd4;
  localparam logic [2:0] REG_LBA_HI   = 3'd5;
  localparam logic [2:0] REG_DEVICE   = 3'd6;
  localparam logic [2:0] REG_STATUS   = 3'd7;
  localparam logic [2:0] REG_COMMAND  = 3'd7;
  // Control block registers (CS1-)
  localparam logic [2:0] REG_ALTSTAT  = 3'd6;
  localparam logic [2:0] REG_DEVCTL   = 3'd6;

  // A zero-length timing parameter still needs one cycle of the phase
  function automatic int at_least_one(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ide_host_pio_sync2.sv
// Two-flop synchroniser for asynchronous device lines (iordy, intrq).
module ide_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_p0;
  logic sync_p1;

  // Two back-to-back flops; the first may go metastable, the second settles it
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/ide_host_pio.sv
// Host-side ATA PIO engine: one register access per request, timed CS/DA/DIOR-/DIOW-
// cycles with IORDY wait and timeout, plus a bus hardware reset pulse.
module ide_host_pio
  import ide_host_pkg::*;
#(
  parameter int T_SETUP   = 3,
  parameter int T_ACTIVE  = 8,
  parameter int T_HOLD    = 2,
  parameter int T_RECOVER = 6,
  parameter int RDY_TMO   = 1024,
  parameter int RST_LEN   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_cs1,
  input  logic [2:0]  req_addr,
  input  logic [15:0] req_wdata,
  input  logic        req_busrst,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  input  logic [15:0] dd_in,
  output logic [15:0] dd_out,
  output logic        dd_oe,
  output logic [2:0]  da,
  output logic        cs0n,
  output logic        cs1n,
  output logic        diorn,
  output logic        diown,
  input  logic        iordy,
  input  logic        intrq,
  output logic        intrq_sync,
  output logic        bus_reset_n
);

  localparam int SETUP_EFF   = at_least_one(T_SETUP);
  localparam int ACTIVE_EFF  = at_least_one(T_ACTIVE);
  localparam int HOLD_EFF    = at_least_one(T_HOLD);
  localparam int RECOVER_EFF = at_least_one(T_RECOVER);
  localparam int RDY_EFF     = at_least_one(RDY_TMO);
  localparam int RST_EFF     = at_least_one(RST_LEN);

  localparam int CNT_MAX = max2(max2(max2(SETUP_EFF, ACTIVE_EFF), max2(HOLD_EFF, RECOVER_EFF)),
                                RST_EFF);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TMO_W   = $clog2(RDY_EFF + 1);

  localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_EFF - 1);
  localparam logic [CNT_W-1:0] ACTIVE_LD  = CNT_W'(ACTIVE_EFF - 1);
  localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_EFF - 1);
  localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(RECOVER_EFF - 1);
  localparam logic [CNT_W-1:0] RST_LD     = CNT_W'(RST_EFF - 1);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(RDY_EFF - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [TMO_W-1:0] tmo;
  logic             wr_l;
  logic [15:0]      rd_lat;
  logic             err_lat;
  logic             iordy_s;
  logic             release_now;
  logic             timeout_now;
  logic [15:0]      cap_data;

  ide_sync2 u_sync_iordy (.clk(clk), .rst(rst), .d(iordy), .q(iordy_s));
  ide_sync2 u_sync_intrq (.clk(clk), .rst(rst), .d(intrq), .q(intrq_sync));

  assign req_ready = (state == S_IDLE) && !rst;

  // Strobe release: active time done with IORDY high, or the IORDY wait has expired
  always_comb begin
    timeout_now = (state == S_WAITRDY) && !iordy_s && (tmo == TMO_LAST);
    release_now = ((state == S_STROBE) && (cnt == '0) && iordy_s) ||
                  ((state == S_WAITRDY) && (iordy_s || (tmo == TMO_LAST)));
    cap_data    = timeout_now ? 16'hFFFF : (wr_l ? 16'h0000 : dd_in);
  end

  // Cycle sequencer with registered bus and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      tmo         <= '0;
      wr_l        <= 1'b0;
      rd_lat      <= 16'h0000;
      err_lat     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 16'h0000;
      rsp_err     <= 1'b0;
      dd_oe       <= 1'b0;
      dd_out      <= 16'h0000;
      da          <= 3'd0;
      cs0n        <= CS_IDLE;
      cs1n        <= CS_IDLE;
      diorn       <= STROBE_NEGATE;
      diown       <= STROBE_NEGATE;
      bus_reset_n <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            wr_l <= req_write;
            if (req_busrst) begin
              state       <= S_RSTLO;
              bus_reset_n <= 1'b0;
              cnt         <= RST_LD;
              if (RST_EFF == 1) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= 16'h0000;
                rsp_err   <= 1'b0;
              end
            end else begin
              state  <= S_SETUP;
              da     <= req_addr;
              cs0n   <= req_cs1 ? CS_IDLE : CS_SELECT;
              cs1n   <= req_cs1 ? CS_SELECT : CS_IDLE;
              dd_oe  <= req_write;
              dd_out <= req_wdata;
              cnt    <= SETUP_LD;
            end
          end
        end
        S_SETUP: begin
          if (cnt == '0) begin
            state <= S_STROBE;
            diorn <= wr_l ? STROBE_NEGATE : STROBE_ASSERT;
            diown <= wr_l ? STROBE_ASSERT : STROBE_NEGATE;
            cnt   <= ACTIVE_LD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_STROBE: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (!iordy_s) begin
            state <= S_WAITRDY;
            tmo   <= '0;
          end
        end
        S_WAITRDY: begin
          if (!release_now) begin
            tmo <= tmo + TMO_W'(1);
          end
        end
        S_HOLD: begin
          if (cnt == CNT_W'(1)) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= rd_lat;
            rsp_err   <= err_lat;
          end
          if (cnt == '0) begin
            state <= S_RECOVER;
            cs0n  <= CS_IDLE;
            cs1n  <= CS_IDLE;
            dd_oe <= 1'b0;
            cnt   <= RECOVER_LD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RECOVER: begin
          cs0n  <= CS_IDLE;
          cs1n  <= CS_IDLE;
          dd_oe <= 1'b0;
          if (cnt == '0) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RSTLO: begin
          if (cnt == CNT_W'(1)) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= 16'h0000;
            rsp_err   <= 1'b0;
          end
          if (cnt == '0) begin
            state       <= S_RECOVER;
            bus_reset_n <= 1'b1;
            cnt         <= RECOVER_LD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase

      if (release_now) begin
        state   <= S_HOLD;
        diorn   <= STROBE_NEGATE;
        diown   <= STROBE_NEGATE;
        cnt     <= HOLD_LD;
        rd_lat  <= cap_data;
        err_lat <= timeout_now;
        if (HOLD_EFF == 1) begin
          rsp_valid <= 1'b1;
          rsp_rdata <= cap_data;
          rsp_err   <= timeout_now;
        end
      end
    end
  end

endmodule

// File: tb/tb_ide_host_pio.sv
// Directed bench for ide_host_pio: a response scoreboard plus bus activity counters.
module tb_ide_host_pio;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_cs1;
  logic [2:0]  req_addr;
  logic [15:0] req_wdata;
  logic        req_busrst;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] dd_in;
  logic [15:0] dd_out;
  logic        dd_oe;
  logic [2:0]  da;
  logic        cs0n;
  logic        cs1n;
  logic        diorn;
  logic        diown;
  logic        iordy;
  logic        intrq;
  logic        intrq_sync;
  logic        bus_reset_n;

  always #5 clk = ~clk;

  ide_host_pio dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_cs1(req_cs1), .req_addr(req_addr), .req_wdata(req_wdata), .req_busrst(req_busrst),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dd_in(dd_in), .dd_out(dd_out), .dd_oe(dd_oe), .da(da),
    .cs0n(cs0n), .cs1n(cs1n), .diorn(diorn), .diown(diown),
    .iordy(iordy), .intrq(intrq), .intrq_sync(intrq_sync), .bus_reset_n(bus_reset_n)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Device model: fixed read data; IORDY always high, low for 28 strobe cycles, or stuck low
  logic [15:0] dev_data = 16'h0000;
  int          rdy_mode = 0;
  int          strobe_age = 0;

  always @(negedge clk) begin
    if (!diorn || !diown) strobe_age <= strobe_age + 1;
    else                  strobe_age <= 0;
  end

  assign dd_in = dev_data;
  assign iordy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (strobe_age >= 28) : 1'b0;

  // Bus activity counters
  int n_rd_lo = 0, n_wr_lo = 0, n_oe = 0, n_cs0 = 0, n_cs1 = 0, n_rstlo = 0;
  int n_rsp = 0, n_da_bad = 0, n_dd_bad = 0, n_viol = 0;
  logic [2:0]  exp_da = 3'd0;
  logic [15:0] exp_dd = 16'h0000;

  always @(negedge clk) begin
    if (!rst) begin
      if (!diorn) n_rd_lo++;
      if (!diown) n_wr_lo++;
      if (dd_oe) n_oe++;
      if (!cs0n) n_cs0++;
      if (!cs1n) n_cs1++;
      if (!bus_reset_n) n_rstlo++;
      if ((!cs0n || !cs1n) && da != exp_da) n_da_bad++;
      if (dd_oe && dd_out != exp_dd) n_dd_bad++;
      if ((!diorn && !diown) || (!cs0n && !cs1n)) n_viol++;
    end
  end

  // Response scoreboard
  typedef struct packed {
    logic        chk_data;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   last_rsp_cyc = 0;

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      n_rsp++;
      last_rsp_cyc = cyc;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected: got rsp_valid rdata=%h err=%0d, required no response",
                 rsp_rdata, rsp_err);
      end else begin
        e_mon = exp_q.pop_front();
        if (rsp_err !== e_mon.err || (e_mon.chk_data && rsp_rdata !== e_mon.rdata)) begin
          bad++;
          $display("FAIL rsp: got rdata=%h err=%0d, required rdata=%h err=%0d",
                   rsp_rdata, rsp_err, e_mon.rdata, e_mon.err);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  int acc_cyc   = 0;
  int ready_cyc = 0;

  task automatic issue(input logic wr, input logic c1, input logic [2:0] a,
                       input logic [15:0] wd, input logic br);
    int n;
    n = 0;
    req_valid  = 1'b1;
    req_write  = wr;
    req_cs1    = c1;
    req_addr   = a;
    req_wdata  = wd;
    req_busrst = br;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", int'(n < 100), 1);
    acc_cyc = cyc;
    @(negedge clk);
    req_valid  = 1'b0;
    req_busrst = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", int'(n < 3000), 1);
    ready_cyc = cyc;
  endtask

  task automatic run_txn(input string nm, input logic wr, input logic c1, input logic [2:0] a,
                         input logic [15:0] wd, input logic br,
                         input logic chkd, input logic [15:0] erd, input logic eerr,
                         input int e_rd, input int e_wr, input int e_oe,
                         input int e_cs0, input int e_cs1, input int e_rst, input int e_lat);
    int s_rd, s_wr, s_oe, s_cs0, s_cs1, s_rst, s_rsp;
    exp_t x;
    s_rd = n_rd_lo; s_wr = n_wr_lo; s_oe = n_oe; s_cs0 = n_cs0; s_cs1 = n_cs1;
    s_rst = n_rstlo; s_rsp = n_rsp;
    x.chk_data = chkd; x.rdata = erd; x.err = eerr;
    exp_q.push_back(x);
    exp_da = a;
    exp_dd = wd;
    issue(wr, c1, a, wd, br);
    wait_ready();
    chk({nm, "_diorn_lo"}, n_rd_lo - s_rd, e_rd);
    chk({nm, "_diown_lo"}, n_wr_lo - s_wr, e_wr);
    chk({nm, "_dd_oe"}, n_oe - s_oe, e_oe);
    chk({nm, "_cs0_lo"}, n_cs0 - s_cs0, e_cs0);
    chk({nm, "_cs1_lo"}, n_cs1 - s_cs1, e_cs1);
    chk({nm, "_busrst_lo"}, n_rstlo - s_rst, e_rst);
    chk({nm, "_rsp_count"}, n_rsp - s_rsp, 1);
    chk({nm, "_latency"}, last_rsp_cyc - acc_cyc, e_lat);
    chk({nm, "_ready_gap"}, ready_cyc - last_rsp_cyc, 7);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rsp0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_cs1    = 1'b0;
    req_addr   = 3'd0;
    req_wdata  = 16'h0000;
    req_busrst = 1'b0;
    intrq      = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("ready_in_reset", int'(req_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", int'(req_ready), 1);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_rdata", int'(rsp_rdata), 0);
    chk("rst_rsp_err", int'(rsp_err), 0);
    chk("rst_dd_oe", int'(dd_oe), 0);
    chk("rst_dd_out", int'(dd_out), 0);
    chk("rst_da", int'(da), 0);
    chk("rst_cs0n", int'(cs0n), 1);
    chk("rst_cs1n", int'(cs1n), 1);
    chk("rst_diorn", int'(diorn), 1);
    chk("rst_diown", int'(diown), 1);
    chk("rst_bus_reset_n", int'(bus_reset_n), 1);
    chk("rst_intrq_sync", int'(intrq_sync), 0);

    // intrq synchroniser: two edges of delay
    intrq = 1'b1;
    @(negedge clk);
    chk("intrq_sync_1edge", int'(intrq_sync), 0);
    @(negedge clk);
    chk("intrq_sync_2edge", int'(intrq_sync), 1);
    intrq = 1'b0;

    // Read STATUS (CS0, DA=7), IORDY high
    dev_data = 16'h0050;
    run_txn("rd_status", 1'b0, 1'b0, 3'd7, 16'h0000, 1'b0, 1'b1, 16'h0050, 1'b0,
            8, 0, 0, 13, 0, 0, 13);

    // Write DEVCTL (CS1, DA=6) = 0x0004
    run_txn("wr_devctl", 1'b1, 1'b1, 3'd6, 16'h0004, 1'b0, 1'b0, 16'h0000, 1'b0,
            0, 8, 13, 0, 13, 0, 13);

    // Read ERROR (CS0, DA=1)
    dev_data = 16'hA5C3;
    run_txn("rd_error", 1'b0, 1'b0, 3'd1, 16'h0000, 1'b0, 1'b1, 16'hA5C3, 1'b0,
            8, 0, 0, 13, 0, 0, 13);

    // Read with IORDY low for 20 cycles past the active time: 8+20+2 strobe-low cycles
    dev_data = 16'h1F2E;
    rdy_mode = 1;
    run_txn("rd_iordy_wait", 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h1F2E, 1'b0,
            30, 0, 0, 35, 0, 0, 35);

    // IORDY stuck low: strobe released after 8+1024 cycles, error response
    dev_data = 16'h3333;
    rdy_mode = 2;
    run_txn("rd_timeout", 1'b0, 1'b0, 3'd7, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 1'b1,
            1032, 0, 0, 1037, 0, 0, 1037);

    // Next request after a timeout is served normally
    rdy_mode = 0;
    dev_data = 16'hBEEF;
    run_txn("rd_after_tmo", 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 1'b0,
            8, 0, 0, 13, 0, 0, 13);

    // Bus hardware reset
    run_txn("bus_reset", 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0,
            0, 0, 0, 0, 0, 64, 64);

    // rst asserted in the middle of the strobe: no response for the aborted read
    dev_data = 16'hDEAD;
    exp_da   = 3'd2;
    rsp0     = n_rsp;
    issue(1'b0, 1'b0, 3'd2, 16'h0000, 1'b0);
    n = 0;
    while (diorn !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_strobe_seen", int'(diorn), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_diorn", int'(diorn), 1);
    chk("abort_diown", int'(diown), 1);
    chk("abort_cs0n", int'(cs0n), 1);
    chk("abort_cs1n", int'(cs1n), 1);
    chk("abort_dd_oe", int'(dd_oe), 0);
    chk("abort_rsp_valid", int'(rsp_valid), 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_no_rsp", n_rsp - rsp0, 0);

    // New request after the abort
    dev_data = 16'h1234;
    run_txn("rd_after_rst", 1'b0, 1'b0, 3'd4, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0,
            8, 0, 0, 13, 0, 0, 13);

    // Whole-run bus invariants
    chk("strobe_cs_exclusive", n_viol, 0);
    chk("da_stable_while_cs", n_da_bad, 0);
    chk("dd_out_stable_while_oe", n_dd_bad, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
